// File: rtl/uart_rx_ctrl.sv
// UART receive-path controller: 16x oversample enable generator, rdy/rdy_clr
// capture handshake and a first-word-fall-through byte FIFO with sticky overrun.
module uart_rx_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [15:0]            divisor,
  output logic                   rx_clken,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  output logic                   rx_rdy_clr,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun,
  input  logic                   overrun_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_PTR   = CW'(DEPTH - 1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t        state;
  logic [15:0]   baud_cnt;
  logic          baud_run;
  logic [7:0]    mem [DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic          push_req;
  logic          push_ok;
  logic          pop;

  // baud_run is enable delayed by one edge so the pulse decodes from flops only
  assign rx_clken = baud_run && (baud_cnt == 16'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= 16'd0;
      baud_run <= 1'b0;
    end else begin
      baud_run <= enable;
      if (!enable)
        baud_cnt <= 16'd0;
      else if (rx_clken)
        baud_cnt <= divisor;
      else if (baud_cnt != 16'd0)
        baud_cnt <= baud_cnt - 16'd1;
    end
  end

  assign empty    = (count == '0);
  assign pop      = rd_en && !empty;
  assign push_req = (state == IDLE) && rx_rdy;
  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign push_ok  = push_req && ((count < FULL_COUNT) || pop);
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rx_rdy_clr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_rdy) begin
            state      <= ACK;
            rx_rdy_clr <= 1'b1;
          end
        end
        ACK: begin
          state      <= IDLE;
          rx_rdy_clr <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          rx_rdy_clr <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 8'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= rx_data;
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + CW'(1);
      end
      if (pop)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + CW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop in the same cycle as a clear leaves the flag set
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overrun <= 1'b0;
    else if (push_req && !push_ok)
      overrun <= 1'b1;
    else if (overrun_clr)
      overrun <= 1'b0;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Controller that sequences the UART receive path. It generates the 16x-oversample clock enable that paces the receiver, and acknowledges each completed byte over the receiver's `rdy`/`rdy_clr` handshake. Received bytes go into a small first-word-fall-through FIFO with a sticky overrun flag, which the CPU-side UART register block drains. It sits between the receiver and the bus-facing UART registers.

## Interface
- `DEPTH`, default 8: FIFO entries; must be a power of two, ≥ 2.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  baud generator run.
- `divisor`  in  16  clken period minus one, in `clk` cycles.
- `rx_clken`  out  1  oversample enable to the receiver.
- `rx_rdy`  in  1  receiver byte-ready flag.
- `rx_data`  in  8  receiver byte.
- `rx_rdy_clr`  out  1  receiver ready-clear.
- `rd_en`  in  1  pop the FIFO head.
- `rd_data`  out  8  FIFO head; valid when `empty`=0.
- `empty`  out  1  FIFO empty.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overrun`  out  1  sticky: a byte was dropped.
- `overrun_clr`  in  1  clear `overrun`.

## Operation
- **Reset values:** `rx_clken`=0, `rx_rdy_clr`=0, `empty`=1, `count`=0, `overrun`=0, `rd_data`=0. Baud counter=0. FSM in IDLE. Pointers=0.
- **Baud generator:**
  - 16-bit down-counter.
  - `enable`=0: counter forced to 0 and `rx_clken`=0.
  - `enable`=1: when the counter is 0, `rx_clken`=1 for that cycle and the counter reloads `divisor`. Otherwise the counter decrements.
  - `divisor`=0 gives `rx_clken` every cycle. A `divisor` change takes effect at the next reload.
  - `rx_clken` is decoded from registered state only.
- **Capture FSM (states IDLE, ACK):**
  - IDLE, `rx_rdy`=1: push `rx_data`, or drop it and set `overrun` if the push is refused. Go to ACK.
  - ACK: `rx_rdy_clr`=1 (registered) for exactly one cycle. `rx_rdy` is ignored in this state. Always return to IDLE.
  - Back in IDLE, `rx_rdy` reflects only bytes completed after the clear, so a byte finishing during ACK is captured next.
  - The FSM runs independently of `enable`.
- **FIFO:**
  - Write pointer, read pointer and count are `$clog2(DEPTH)` + 1 bits wide. Pointers wrap modulo `DEPTH`.
  - `rd_data` = mem[rd_ptr]. Asserting `rd_en` while `empty`=1 has no effect.
  - Push is accepted if `count` < `DEPTH`, or if `count`=`DEPTH` and an effective pop occurs the same cycle.
  - Push and pop together leave `count` unchanged.
  - `empty` = (`count`==0).
- **Overrun:** when set and `overrun_clr` occur in the same cycle, set wins. The FIFO contents are not disturbed by an overrun.
- **Reset mid-operation:** everything returns to reset values immediately. Buffered bytes are lost.

## Timing
- `rx_rdy` high at edge k in IDLE:
  - FIFO write at edge k, so `count`/`empty` update after edge k.
  - `rx_rdy_clr` high during cycle k..k+1 and low again after edge k+1.
  - Throughput: 1 byte per 2 clk, far above the line rate.
- Pop with `rd_en` at edge k: `rd_data`/`count` reflect the new head after edge k.
- `rx_clken` with constant `divisor` D: period exactly D+1 cycles. First pulse is in the first cycle after `enable` rises.

## Test plan
- **Baud generator:** `divisor`=3, `enable`=1 for 20 cycles → `rx_clken` pulses every 4th cycle, 5 pulses. Drop `enable` → no pulses, counter 0.
- **Single byte:** `rx_rdy` with `rx_data`=0xA5 → `rx_rdy_clr` high exactly one cycle, one cycle after detection. `empty`=0, `count`=1, `rd_data`=0xA5. `rd_en` → `empty`=1.
- **Ordering and wrap:** 20 bytes 0x00..0x13 with interleaved reads, `DEPTH`=8 → read order preserved across pointer wrap, `overrun` stays 0.
- **Overrun:** 9 bytes with no reads → `count`=8, `overrun`=1, FIFO holds 0x00..0x07. `overrun_clr` alone → 0. `overrun_clr` with a drop in the same cycle → stays 1.
- **Full boundary:** full FIFO, push and `rd_en` in the same cycle → push accepted, `count` stays 8, `overrun` stays 0.
- **Reset:** assert `reset` with 3 bytes buffered and the FSM in ACK → all outputs at reset values immediately, including `rx_rdy_clr`=0 and `count`=0.
